sdram_wr_burst: RTL and testbench
=================================

# sdram_wr_burst

Write-side burst packer between the write FIFO's read port and the SDRAM controller's write channel. Monitors FIFO fill level, requests a write burst once a full burst of words is buffered, streams FIFO words to the controller on its per-word data requests, and advances a wrapping SDRAM write address. Single clock domain; the FIFO read clock is this block's clock.

## Interface
- DATA_WIDTH, 16: data word width.
- USE_NUM_WIDTH, 10: width of FIFO fill count.
- ADDR_WIDTH, 24: SDRAM word address width.
- BURST_LEN, 8: words per full burst, 1..255.
- ADDR_BASE, 0: first write address and wrap target.
- ADDR_LIMIT, 24'hFFFFFF: last writable address, inclusive.

Ports:
- clk  in  1  clock; all logic on rising edge.
- clr  in  1  asynchronous, active-high reset.
- enable  in  1  allows new bursts to start.
- fifo_use_num  in  USE_NUM_WIDTH  FIFO read-side fill count.
- fifo_rd_req  out  1  FIFO read strobe; data valid one cycle later.
- fifo_rd_data  in  DATA_WIDTH  FIFO read data.
- sdram_wr_req  out  1  burst request, held until ack.
- sdram_wr_ack  in  1  controller accepts burst.
- sdram_wr_addr  out  ADDR_WIDTH  burst start address, stable while req high.
- sdram_wr_len  out  8  burst word count.
- sdram_wr_data_req  in  1  controller requests one word.
- sdram_wr_data  out  DATA_WIDTH  word for the controller.
- sdram_wr_done  in  1  controller finished burst.
- burst_err  out  1  sticky protocol-error flag.
- flush  in  1  only with SDRAM_WR_FLUSH_EN; drain partial burst.

## Operation
- States IDLE, REQ, BURST.
- IDLE: if enable and fifo_use_num >= BURST_LEN, load sdram_wr_len = BURST_LEN, go REQ. Otherwise stay.
- REQ: sdram_wr_req = 1; on sdram_wr_ack go BURST, clear word counter.
- BURST: fifo_rd_req = sdram_wr_data_req while word counter < sdram_wr_len; each forwarded request increments counter. sdram_wr_data is combinationally fifo_rd_data.
- sdram_wr_done with counter == sdram_wr_len: address += sdram_wr_len, go IDLE.
- Address wrap: if new address + BURST_LEN - 1 > ADDR_LIMIT, load ADDR_BASE instead. Compute at ADDR_WIDTH+1 bits; no silent overflow.
- Error cases, each sets burst_err (cleared only by clr): sdram_wr_data_req in IDLE/REQ or with counter == sdram_wr_len (request ignored, no FIFO read); sdram_wr_done before counter == sdram_wr_len (burst abandoned, address not advanced, go IDLE); sdram_wr_ack outside REQ (ignored).
- enable deassertion mid-burst has no effect; it gates only the IDLE decision.
- clr at any time: immediate return to IDLE, pending burst dropped.

## Timing
- Reset values: fifo_rd_req 0, sdram_wr_req 0, sdram_wr_addr ADDR_BASE, sdram_wr_len BURST_LEN, burst_err 0, state IDLE, counter 0.
- sdram_wr_req rises the cycle after the IDLE condition is sampled true; falls the cycle after ack is sampled.
- Controller samples sdram_wr_data one cycle after each sdram_wr_data_req (FIFO read latency 1).
- Back-to-back data requests supported at one word per cycle.
- Minimum IDLE dwell: one cycle between done and next req.
- Address update visible on sdram_wr_addr the cycle after done.

## Configuration
- SDRAM_WR_FLUSH_EN defined: flush port exists; a flush pulse sets a pending flag. In IDLE with flag set and 0 < fifo_use_num < BURST_LEN, burst issued with sdram_wr_len = fifo_use_num (enable not required); flag clears on that burst's ack, or in IDLE when fifo_use_num == 0. Full-burst condition has priority over flush.
- Not defined: no flush port, sdram_wr_len constant BURST_LEN, partial words remain in FIFO.

## Test plan
- Fill FIFO to 8 (BURST_LEN 8), enable=1 -> req next cycle, after ack 8 fifo_rd_req pulses, data 1..8 out in order, addr 0 then 8 after done.
- fifo_use_num 7, enable=1 -> no sdram_wr_req for 100 cycles.
- ADDR_LIMIT 23, three bursts -> addresses 0, 8, 16, then 0.
- Early done after 5 words -> burst_err=1, addr unchanged, return to IDLE; extra data_req in IDLE -> no fifo_rd_req.
- clr asserted during BURST -> all outputs at reset values same cycle; restart works.
- With SDRAM_WR_FLUSH_EN: 3 words buffered, flush pulse -> burst of len 3, addr advances by 3.

Source files
------------

// File: rtl/sdram_wr_burst.sv
// Write-side burst packer between the write FIFO and the SDRAM controller's write channel.
// Define SDRAM_WR_FLUSH_EN to add the flush port for draining partial bursts.
module sdram_wr_burst #(
    parameter int DATA_WIDTH    = 16,
    parameter int USE_NUM_WIDTH = 10,
    parameter int ADDR_WIDTH    = 24,
    parameter int BURST_LEN     = 8,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = {ADDR_WIDTH{1'b1}}
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     enable,
    input  logic [USE_NUM_WIDTH-1:0] fifo_use_num,
    output logic                     fifo_rd_req,
    input  logic [DATA_WIDTH-1:0]    fifo_rd_data,
    output logic                     sdram_wr_req,
    input  logic                     sdram_wr_ack,
    output logic [ADDR_WIDTH-1:0]    sdram_wr_addr,
    output logic [7:0]               sdram_wr_len,
    input  logic                     sdram_wr_data_req,
    output logic [DATA_WIDTH-1:0]    sdram_wr_data,
    input  logic                     sdram_wr_done,
`ifdef SDRAM_WR_FLUSH_EN
    input  logic                     flush,
`endif
    output logic                     burst_err
);

    localparam logic [USE_NUM_WIDTH-1:0] USE_BURST = USE_NUM_WIDTH'(BURST_LEN);
    localparam logic [7:0]               LEN_BURST = 8'(BURST_LEN);
    localparam logic [ADDR_WIDTH:0]      SPAN_M1   = (ADDR_WIDTH + 1)'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH:0]      LIMIT_EXT = {1'b0, ADDR_LIMIT};

    typedef enum logic [1:0] {IDLE, REQ, BURST} state_t;

    state_t            state;
    logic [7:0]        word_cnt;
    logic              burst_open;
    logic              full_ready;
    logic [ADDR_WIDTH:0] next_addr;
    logic              wrap;

    assign burst_open  = word_cnt < sdram_wr_len;
    assign full_ready  = enable && (fifo_use_num >= USE_BURST);
    assign fifo_rd_req = (state == BURST) && sdram_wr_data_req && burst_open;
    assign sdram_wr_data = fifo_rd_data;

    // One extra bit so an address near the top cannot silently wrap past ADDR_LIMIT
    assign next_addr = {1'b0, sdram_wr_addr} + {{(ADDR_WIDTH - 7){1'b0}}, sdram_wr_len};
    assign wrap      = (next_addr + SPAN_M1) > LIMIT_EXT;

`ifdef SDRAM_WR_FLUSH_EN
    logic flush_pend;
    logic flush_burst;
    logic flush_ready;

    assign flush_ready = flush_pend && (fifo_use_num != '0) && (fifo_use_num < USE_BURST);
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state         <= IDLE;
            sdram_wr_req  <= 1'b0;
            sdram_wr_addr <= ADDR_BASE;
            sdram_wr_len  <= LEN_BURST;
            burst_err     <= 1'b0;
            word_cnt      <= '0;
`ifdef SDRAM_WR_FLUSH_EN
            flush_pend    <= 1'b0;
            flush_burst   <= 1'b0;
`endif
        end else begin
            // Any data request not turned into a FIFO read is a protocol violation
            if ((sdram_wr_data_req && !fifo_rd_req) ||
                (sdram_wr_ack && state != REQ) ||
                (state == BURST && sdram_wr_done && burst_open))
                burst_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (full_ready) begin
                        sdram_wr_len <= LEN_BURST;
                        sdram_wr_req <= 1'b1;
                        state        <= REQ;
`ifdef SDRAM_WR_FLUSH_EN
                        flush_burst  <= 1'b0;
                    end else if (flush_ready) begin
                        sdram_wr_len <= fifo_use_num[7:0];
                        sdram_wr_req <= 1'b1;
                        state        <= REQ;
                        flush_burst  <= 1'b1;
`endif
                    end
`ifdef SDRAM_WR_FLUSH_EN
                    if (fifo_use_num == '0)
                        flush_pend <= 1'b0;
`endif
                end
                REQ: begin
                    if (sdram_wr_ack) begin
                        sdram_wr_req <= 1'b0;
                        word_cnt     <= '0;
                        state        <= BURST;
`ifdef SDRAM_WR_FLUSH_EN
                        if (flush_burst)
                            flush_pend <= 1'b0;
`endif
                    end
                end
                BURST: begin
                    if (fifo_rd_req)
                        word_cnt <= word_cnt + 8'd1;
                    // An early done abandons the burst without moving the address
                    if (sdram_wr_done) begin
                        state <= IDLE;
                        if (!burst_open)
                            sdram_wr_addr <= wrap ? ADDR_BASE : next_addr[ADDR_WIDTH-1:0];
                    end
                end
                default: state <= IDLE;
            endcase

`ifdef SDRAM_WR_FLUSH_EN
            if (flush)
                flush_pend <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_sdram_wr_burst.sv
// Directed bench for sdram_wr_burst with ADDR_LIMIT 23 so the address wraps after three bursts.
// Build with SDRAM_WR_FLUSH_EN defined to also exercise the partial-burst flush.
module tb_sdram_wr_burst;

    localparam int DW = 16;
    localparam int UW = 10;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          clr;
    logic          enable;
    logic [UW-1:0] fifo_use_num;
    logic          fifo_rd_req;
    logic [DW-1:0] fifo_rd_data;
    logic          sdram_wr_req;
    logic          sdram_wr_ack;
    logic [AW-1:0] sdram_wr_addr;
    logic [7:0]    sdram_wr_len;
    logic          sdram_wr_data_req;
    logic [DW-1:0] sdram_wr_data;
    logic          sdram_wr_done;
    logic          burst_err;
`ifdef SDRAM_WR_FLUSH_EN
    logic          flush;
`endif

    logic [DW-1:0] mem [0:63];
    logic [5:0]    wr_ptr;
    logic [5:0]    rd_ptr = '0;
    logic [DW-1:0] next_val;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sdram_wr_burst #(
        .DATA_WIDTH(DW), .USE_NUM_WIDTH(UW), .ADDR_WIDTH(AW), .BURST_LEN(8),
        .ADDR_BASE(24'd0), .ADDR_LIMIT(24'd23)
    ) dut (
        .clk(clk),
        .clr(clr),
        .enable(enable),
        .fifo_use_num(fifo_use_num),
        .fifo_rd_req(fifo_rd_req),
        .fifo_rd_data(fifo_rd_data),
        .sdram_wr_req(sdram_wr_req),
        .sdram_wr_ack(sdram_wr_ack),
        .sdram_wr_addr(sdram_wr_addr),
        .sdram_wr_len(sdram_wr_len),
        .sdram_wr_data_req(sdram_wr_data_req),
        .sdram_wr_data(sdram_wr_data),
        .sdram_wr_done(sdram_wr_done),
`ifdef SDRAM_WR_FLUSH_EN
        .flush(flush),
`endif
        .burst_err(burst_err)
    );

    // FIFO model with one cycle read latency
    assign fifo_use_num = {4'b0, 6'(wr_ptr - rd_ptr)};
    always @(posedge clk) begin
        if (fifo_rd_req) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 6'd1;
        end
    end

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = next_val;
            wr_ptr      = wr_ptr + 6'd1;
            next_val    = next_val + 16'd1;
        end
    endtask

    function automatic logic [127:0] expect_words(input int first, input int n);
        logic [127:0] w;
        w = '0;
        for (int i = 0; i < n; i++)
            w[i*16 +: 16] = 16'(first + i);
        return w;
    endfunction

    // Acts as the controller for one burst of n words; reports what it observed
    task automatic run_burst(input int n, output logic [AW-1:0] addr_seen, output logic [7:0] len_seen,
                             output int pulses, output logic [127:0] words,
                             output logic req_after_ack, output bit got_req);
        addr_seen = 'x; len_seen = 'x; pulses = 0; words = '0; req_after_ack = 1'bx; got_req = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (sdram_wr_req) begin
                got_req = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got_req) return;
        addr_seen    = sdram_wr_addr;
        len_seen     = sdram_wr_len;
        sdram_wr_ack = 1'b1;
        @(negedge clk);
        sdram_wr_ack  = 1'b0;
        req_after_ack = sdram_wr_req;
        for (int i = 0; i <= n; i++) begin
            if (i > 0) words[(i-1)*16 +: 16] = sdram_wr_data;
            if (i < n) begin
                sdram_wr_data_req = 1'b1;
                #1;
                if (fifo_rd_req) pulses++;
                @(negedge clk);
            end else begin
                sdram_wr_data_req = 1'b0;
                sdram_wr_done     = 1'b1;
                @(negedge clk);
                sdram_wr_done     = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; enable = 1'b0; sdram_wr_ack = 1'b0; sdram_wr_data_req = 1'b0; sdram_wr_done = 1'b0;
        wr_ptr = '0; next_val = 16'd1;
`ifdef SDRAM_WR_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (2) @(negedge clk);
        vectors++;
        if ({fifo_rd_req, sdram_wr_req, burst_err} !== 3'b000) begin
            miscompares++; $display("[TB] FAIL reset_flags: got %b expected 000", {fifo_rd_req, sdram_wr_req, burst_err});
        end
        vectors++;
        if (sdram_wr_addr !== 24'd0 || sdram_wr_len !== 8'd8) begin
            miscompares++; $display("[TB] FAIL reset_addr_len: got %0d/%0d expected 0/8", sdram_wr_addr, sdram_wr_len);
        end
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [AW-1:0] a; logic [7:0] l; int p; logic [127:0] w; logic r; bit ok;
        push_words(8);
        enable = 1'b1;
        #1;
        vectors++;
        if (sdram_wr_req !== 1'b0) begin
            miscompares++; $display("[TB] FAIL req_early: got %b expected 0", sdram_wr_req);
        end
        @(negedge clk);
        vectors++;
        if (sdram_wr_req !== 1'b1 || sdram_wr_addr !== 24'd0 || sdram_wr_len !== 8'd8) begin
            miscompares++; $display("[TB] FAIL req_next_cycle: got req %b addr %0d len %0d expected 1/0/8",
                                    sdram_wr_req, sdram_wr_addr, sdram_wr_len);
        end
        run_burst(8, a, l, p, w, r, ok);
        vectors++;
        if (!ok || r !== 1'b0 || p != 8) begin
            miscompares++; $display("[TB] FAIL basic_handshake: got req %b after_ack %b pulses %0d expected 1/0/8", ok, r, p);
        end
        vectors++;
        if (w !== expect_words(1, 8)) begin
            miscompares++; $display("[TB] FAIL basic_data: got %h expected %h", w, expect_words(1, 8));
        end
        vectors++;
        if (sdram_wr_addr !== 24'd8 || sdram_wr_req !== 1'b0) begin
            miscompares++; $display("[TB] FAIL basic_addr_next: got %0d req %b expected 8/0", sdram_wr_addr, sdram_wr_req);
        end
    endtask

    task automatic test_threshold_and_wrap();
        logic [AW-1:0] a; logic [7:0] l; int p; logic [127:0] w; logic r; bit ok; bit seen;
        push_words(7);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sdram_wr_req) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++; $display("[TB] FAIL below_threshold: got req 1 expected 0");
        end
        push_words(1);
        run_burst(8, a, l, p, w, r, ok);
        vectors++;
        if (!ok || a !== 24'd8 || w !== expect_words(9, 8)) begin
            miscompares++; $display("[TB] FAIL burst2: got addr %0d data %h expected 8/%h", a, w, expect_words(9, 8));
        end
        push_words(8);
        run_burst(8, a, l, p, w, r, ok);
        vectors++;
        if (!ok || a !== 24'd16 || w !== expect_words(17, 8)) begin
            miscompares++; $display("[TB] FAIL burst3: got addr %0d data %h expected 16/%h", a, w, expect_words(17, 8));
        end
        vectors++;
        if (sdram_wr_addr !== 24'd0) begin
            miscompares++; $display("[TB] FAIL wrap: got %0d expected 0", sdram_wr_addr);
        end
        push_words(8);
        run_burst(8, a, l, p, w, r, ok);
        vectors++;
        if (!ok || a !== 24'd0 || sdram_wr_addr !== 24'd8 || burst_err !== 1'b0) begin
            miscompares++; $display("[TB] FAIL burst4: got addr %0d next %0d err %b expected 0/8/0", a, sdram_wr_addr, burst_err);
        end
    endtask

    task automatic test_early_done();
        bit ok;
        push_words(8);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (sdram_wr_req) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        vectors++;
        if (!ok) begin
            miscompares++; $display("[TB] FAIL early_req: got no req expected req within 20 cycles");
        end
        sdram_wr_ack = 1'b1;
        @(negedge clk);
        sdram_wr_ack = 1'b0;
        repeat (5) begin
            sdram_wr_data_req = 1'b1;
            @(negedge clk);
        end
        sdram_wr_data_req = 1'b0;
        sdram_wr_done     = 1'b1;
        @(negedge clk);
        sdram_wr_done = 1'b0;
        vectors++;
        if (burst_err !== 1'b1 || sdram_wr_addr !== 24'd8 || sdram_wr_req !== 1'b0) begin
            miscompares++; $display("[TB] FAIL early_done: got err %b addr %0d req %b expected 1/8/0",
                                    burst_err, sdram_wr_addr, sdram_wr_req);
        end
        sdram_wr_data_req = 1'b1;
        #1;
        vectors++;
        if (fifo_rd_req !== 1'b0) begin
            miscompares++; $display("[TB] FAIL idle_data_req: got rd_req %b expected 0", fifo_rd_req);
        end
        @(negedge clk);
        sdram_wr_data_req = 1'b0;
        vectors++;
        if (fifo_use_num !== 10'd3) begin
            miscompares++; $display("[TB] FAIL fifo_left: got %0d expected 3", fifo_use_num);
        end
    endtask

    task automatic test_clr_and_restart();
        logic [AW-1:0] a; logic [7:0] l; int p; logic [127:0] w; logic r; bit ok;
        push_words(5);
        for (int t = 0; t < 20 && !sdram_wr_req; t++) @(negedge clk);
        sdram_wr_ack = 1'b1;
        @(negedge clk);
        sdram_wr_ack = 1'b0;
        sdram_wr_data_req = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        #1;
        vectors++;
        if ({fifo_rd_req, sdram_wr_req, burst_err} !== 3'b000 || sdram_wr_addr !== 24'd0 || sdram_wr_len !== 8'd8) begin
            miscompares++; $display("[TB] FAIL clr_burst: got flags %b addr %0d len %0d expected 000/0/8",
                                    {fifo_rd_req, sdram_wr_req, burst_err}, sdram_wr_addr, sdram_wr_len);
        end
        sdram_wr_data_req = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        push_words(2);
        run_burst(8, a, l, p, w, r, ok);
        vectors++;
        if (!ok || a !== 24'd0 || w !== expect_words(40, 8) || burst_err !== 1'b0) begin
            miscompares++; $display("[TB] FAIL restart: got addr %0d data %h err %b expected 0/%h/0",
                                    a, w, burst_err, expect_words(40, 8));
        end
        sdram_wr_ack = 1'b1;
        @(negedge clk);
        sdram_wr_ack = 1'b0;
        vectors++;
        if (burst_err !== 1'b1 || sdram_wr_req !== 1'b0) begin
            miscompares++; $display("[TB] FAIL stray_ack: got err %b req %b expected 1/0", burst_err, sdram_wr_req);
        end
    endtask

`ifdef SDRAM_WR_FLUSH_EN
    task automatic test_flush();
        logic [AW-1:0] a; logic [7:0] l; int p; logic [127:0] w; logic r; bit ok;
        enable = 1'b0;
        push_words(3);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        run_burst(3, a, l, p, w, r, ok);
        vectors++;
        if (!ok || l !== 8'd3 || a !== 24'd8 || w !== expect_words(48, 3)) begin
            miscompares++; $display("[TB] FAIL flush_burst: got len %0d addr %0d data %h expected 3/8/%h",
                                    l, a, w, expect_words(48, 3));
        end
        vectors++;
        if (sdram_wr_addr !== 24'd11) begin
            miscompares++; $display("[TB] FAIL flush_addr: got %0d expected 11", sdram_wr_addr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_threshold_and_wrap();
        test_early_done();
        test_clr_and_restart();
`ifdef SDRAM_WR_FLUSH_EN
        test_flush();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
